decode_issue: RTL and testbench

- Upstream neighbour of merge_execution.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes it into func, rd, rs1, rs2 and imm.
- Reads the register file and issues the operands to the execution stage through a one-entry pipeline register.
- Owns the register file, its writeback port and a per-register pending scoreboard that stalls RAW/WAW hazards.

---
 rtl/simple_processor_pkg.sv | 43 ++++
 rtl/regfile.sv | 36 +++
 rtl/decode_issue.sv | 139 +++++++++++++
 tb/tb_decode_issue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared definitions for the decode/issue stage: operation encoding, instruction
// field positions and decode helpers.
package simple_processor_pkg;

    typedef enum logic [5:0] {
        FUNC_AND  = 6'd0,
        FUNC_OR   = 6'd1,
        FUNC_XOR  = 6'd2,
        FUNC_ADD  = 6'd3,
        FUNC_SUB  = 6'd4,
        FUNC_SLL  = 6'd5,
        FUNC_SLR  = 6'd6,
        FUNC_NOT  = 6'd7,
        FUNC_ADDI = 6'd8,
        FUNC_SLLI = 6'd9,
        FUNC_SLRI = 6'd10
    } func_t;

    localparam int FUNC_LSB   = 0;
    localparam int FUNC_WIDTH = 6;
    localparam int RD_LSB     = 6;
    localparam int RS1_LSB    = 11;
    localparam int RS2_LSB    = 16;
    localparam int IMM_LSB    = 21;

    // Only register-register operations read the second source.
    function automatic logic uses_rs2(func_t f);
        case (f)
            FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_ADD,
            FUNC_SUB, FUNC_SLL, FUNC_SLR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_func(logic [5:0] f);
        case (f)
            FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_ADD, FUNC_SUB, FUNC_SLL,
            FUNC_SLR, FUNC_NOT, FUNC_ADDI, FUNC_SLLI, FUNC_SLRI: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two combinational read ports with write-through bypass and
// one synchronous write port, cleared by synchronous reset.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    logic [DATA_WIDTH-1:0] mem_reg [NUM_REGS];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // A same-cycle writeback is visible to the reader so a stalled consumer can
    // issue in the very cycle its producer retires.
    assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : mem_reg[rd_addr_a];
    assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : mem_reg[rd_addr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one instruction per cycle, checks the pending
// scoreboard for hazards and issues operands through a one-entry register.
module decode_issue
    import simple_processor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int IMM_WIDTH  = 6,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output func_t                 func_o,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic [IMM_WIDTH-1:0]  imm_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic                  wb_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  illegal_o,
    output logic                  busy_o
);

    logic [FUNC_WIDTH-1:0] func_raw;
    logic [ADDR_WIDTH-1:0] rd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [IMM_WIDTH-1:0]  imm;
    logic                  unused_hi_bits;

    assign func_raw       = instr_i[FUNC_LSB +: FUNC_WIDTH];
    assign rd             = instr_i[RD_LSB +: ADDR_WIDTH];
    assign rs1            = instr_i[RS1_LSB +: ADDR_WIDTH];
    assign rs2            = instr_i[RS2_LSB +: ADDR_WIDTH];
    assign imm            = instr_i[IMM_LSB +: IMM_WIDTH];
    assign unused_hi_bits = ^instr_i[31:IMM_LSB+IMM_WIDTH];

    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk       (clk_i),
        .srst      (srst_i),
        .wr_en     (wb_en_i),
        .wr_addr   (wb_addr_i),
        .wr_data   (wb_data_i),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_data),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_data)
    );

    logic                  ex_valid_reg;
    func_t                 func_reg;
    logic [DATA_WIDTH-1:0] rs1_data_reg;
    logic [DATA_WIDTH-1:0] rs2_data_reg;
    logic [IMM_WIDTH-1:0]  imm_reg;
    logic [ADDR_WIDTH-1:0] rd_reg;
    logic                  illegal_reg;
    logic                  busy_reg;
    logic [NUM_REGS-1:0]   pending_reg;
    logic [NUM_REGS-1:0]   pending_next;
    logic [NUM_REGS-1:0]   clr_mask;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   pending_eff;
    logic                  legal;
    logic                  stall;
    logic                  fire;
    logic                  issue;

    // A writeback retiring this cycle already counts as not pending.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_en_i) begin
            clr_mask[wb_addr_i] = 1'b1;
        end
        if (issue) begin
            set_mask[rd] = 1'b1;
        end
    end

    assign pending_eff   = pending_reg & ~clr_mask;
    assign pending_next  = pending_eff | set_mask;
    assign legal         = is_legal_func(func_raw);
    assign stall         = pending_eff[rs1] || pending_eff[rd] ||
                           (uses_rs2(func_t'(func_raw)) && pending_eff[rs2]);
    assign instr_ready_o = !srst_i && !stall && (!ex_valid_reg || ex_ready_i);
    assign fire          = instr_valid_i && instr_ready_o;
    assign issue         = fire && legal;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ex_valid_reg <= 1'b0;
            func_reg     <= FUNC_AND;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
            rd_reg       <= '0;
            illegal_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            pending_reg  <= '0;
        end else begin
            illegal_reg <= fire && !legal;
            pending_reg <= pending_next;
            busy_reg    <= |pending_next;
            if (issue) begin
                ex_valid_reg <= 1'b1;
                func_reg     <= func_t'(func_raw);
                rs1_data_reg <= rs1_data;
                rs2_data_reg <= rs2_data;
                imm_reg      <= imm;
                rd_reg       <= rd;
            end else if (ex_ready_i) begin
                ex_valid_reg <= 1'b0;
            end
        end
    end

    assign ex_valid_o = ex_valid_reg;
    assign func_o     = func_reg;
    assign rs1_data_o = rs1_data_reg;
    assign rs2_data_o = rs2_data_reg;
    assign imm_o      = imm_reg;
    assign rd_addr_o  = rd_reg;
    assign illegal_o  = illegal_reg;
    assign busy_o     = busy_reg;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the stage.
module tb_decode_issue;
    import simple_processor_pkg::*;

    logic        clk = 1'b0;
    logic        srst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        ex_valid_o;
    logic        ex_ready_i;
    func_t       func_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [5:0]  imm_o;
    logic [4:0]  rd_addr_o;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        illegal_o;
    logic        busy_o;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk_i         (clk),
        .srst_i        (srst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .func_o        (func_o),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .imm_o         (imm_o),
        .rd_addr_o     (rd_addr_o),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .illegal_o     (illegal_o),
        .busy_o        (busy_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: architectural registers, in-flight destinations and the
    // operation currently offered to execution.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid;
    logic [5:0]  m_func;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [5:0]  m_imm;
    logic [4:0]  m_rd;
    bit          m_illegal;
    bit          m_ready;

    function automatic bit model_legal(logic [5:0] f);
        return f inside {FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_ADD, FUNC_SUB, FUNC_SLL,
                         FUNC_SLR, FUNC_NOT, FUNC_ADDI, FUNC_SLLI, FUNC_SLRI};
    endfunction

    function automatic bit model_two_src(logic [5:0] f);
        return f inside {FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_ADD, FUNC_SUB, FUNC_SLL, FUNC_SLR};
    endfunction

    function automatic bit waiting_on(logic [4:0] r);
        return m_pend[r] && !(wb_en_i && wb_addr_i == r);
    endfunction

    function automatic logic [31:0] mk(logic [5:0] f, logic [4:0] rd, logic [4:0] rs1,
                                       logic [4:0] rs2, logic [5:0] imm);
        logic [4:0] junk;
        junk = 5'($urandom);
        return {junk, imm, rs2, rs1, rd, f};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [31:0] ins, bit exr, bit wen, logic [4:0] wa, logic [31:0] wd);
        instr_valid_i = v;
        instr_i       = ins;
        ex_ready_i    = exr;
        wb_en_i       = wen;
        wb_addr_i     = wa;
        wb_data_i     = wd;
    endtask

    // One clock: check readiness before the edge, advance the model on the
    // edge, then check every registered output.
    task automatic step();
        logic [5:0]  f;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] op1;
        logic [31:0] op2;
        bit          fire;
        bit          any;
        f   = instr_i[5:0];
        rd  = instr_i[10:6];
        rs1 = instr_i[15:11];
        rs2 = instr_i[20:16];
        m_ready = !srst_i && (!m_valid || ex_ready_i) && !waiting_on(rs1) && !waiting_on(rd)
                  && !(model_two_src(f) && waiting_on(rs2));
        #1;
        check("instr_ready", 64'(instr_ready_o), 64'(m_ready));
        @(posedge clk);
        if (srst_i) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_valid = 0; m_func = FUNC_AND; m_op1 = '0; m_op2 = '0;
            m_imm = '0; m_rd = '0; m_illegal = 0;
        end else begin
            fire = instr_valid_i && m_ready;
            op1  = (wb_en_i && wb_addr_i == rs1) ? wb_data_i : m_regs[rs1];
            op2  = (wb_en_i && wb_addr_i == rs2) ? wb_data_i : m_regs[rs2];
            m_illegal = fire && !model_legal(f);
            if (fire && model_legal(f)) begin
                m_valid = 1; m_func = f; m_op1 = op1; m_op2 = op2;
                m_imm = instr_i[26:21]; m_rd = rd;
            end else if (ex_ready_i) begin
                m_valid = 0;
            end
            if (wb_en_i) begin
                m_regs[wb_addr_i] = wb_data_i;
                m_pend[wb_addr_i] = 1'b0;
            end
            if (fire && model_legal(f)) m_pend[rd] = 1'b1;
        end
        any = 0;
        for (int i = 0; i < 32; i++) any |= m_pend[i];
        #1;
        check("ex_valid", 64'(ex_valid_o), 64'(m_valid));
        check("func", 64'(func_o), 64'(m_func));
        check("rs1_data", 64'(rs1_data_o), 64'(m_op1));
        check("rs2_data", 64'(rs2_data_o), 64'(m_op2));
        check("imm", 64'(imm_o), 64'(m_imm));
        check("rd_addr", 64'(rd_addr_o), 64'(m_rd));
        check("illegal", 64'(illegal_o), 64'(m_illegal));
        check("busy", 64'(busy_o), 64'(any));
    endtask

    initial begin
        m_valid = 0;
        srst_i  = 1'b1;
        drive(0, '0, 1, 0, '0, '0);
        step();
        step();
        check("reset_func", 64'(func_o), 64'(FUNC_AND));
        check("reset_busy", 64'(busy_o), 64'd0);
        srst_i = 1'b0;

        // preload r1=5, r2=7, then ADD r3 = r1 + r2
        drive(0, '0, 1, 1, 5'd1, 32'd5); step();
        drive(0, '0, 1, 1, 5'd2, 32'd7); step();
        drive(1, mk(FUNC_ADD, 5'd3, 5'd1, 5'd2, 6'd0), 1, 0, '0, '0); step();
        check("add_valid", 64'(ex_valid_o), 64'd1);
        check("add_rs1", 64'(rs1_data_o), 64'd5);
        check("add_rs2", 64'(rs2_data_o), 64'd7);
        check("add_rd", 64'(rd_addr_o), 64'd3);
        check("add_busy", 64'(busy_o), 64'd1);

        // RAW on r3: stalls until the writeback, then issues with bypassed data
        drive(1, mk(FUNC_SUB, 5'd5, 5'd3, 5'd2, 6'd0), 1, 0, '0, '0); step();
        check("raw_stall", 64'(instr_ready_o), 64'd0);
        step();
        drive(1, mk(FUNC_SUB, 5'd5, 5'd3, 5'd2, 6'd0), 1, 1, 5'd3, 32'd12);
        #1;
        check("raw_release", 64'(instr_ready_o), 64'd1);
        step();
        check("raw_bypass", 64'(rs1_data_o), 64'd12);

        // backpressure holds the issued SUB, then drains in one cycle
        drive(1, mk(FUNC_ADD, 5'd6, 5'd1, 5'd2, 6'd0), 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) step();
        check("hold_ready", 64'(instr_ready_o), 64'd0);
        check("hold_rs1", 64'(rs1_data_o), 64'd12);
        drive(0, '0, 1, 0, '0, '0); step();
        check("drain", 64'(ex_valid_o), 64'd0);

        // r4 pending must not block ADDI naming r4 as rs2
        drive(1, mk(FUNC_ADD, 5'd4, 5'd1, 5'd2, 6'd0), 1, 0, '0, '0); step();
        drive(1, mk(FUNC_ADDI, 5'd7, 5'd1, 5'd4, 6'h3), 1, 0, '0, '0);
        #1;
        check("addi_ready", 64'(instr_ready_o), 64'd1);
        step();
        check("addi_imm", 64'(imm_o), 64'h3);
        check("addi_func", 64'(func_o), 64'(FUNC_ADDI));

        // illegal func: one-cycle pulse, nothing issued
        drive(1, mk(6'h3F, 5'd8, 5'd9, 5'd10, 6'd0), 1, 0, '0, '0); step();
        check("illegal_pulse", 64'(illegal_o), 64'd1);
        check("illegal_noissue", 64'(ex_valid_o), 64'd0);
        drive(0, '0, 1, 0, '0, '0); step();
        check("illegal_end", 64'(illegal_o), 64'd0);

        // reset while an op is held and r3 is pending
        drive(1, mk(FUNC_ADD, 5'd3, 5'd1, 5'd2, 6'd0), 0, 0, '0, '0); step();
        check("pre_reset_valid", 64'(ex_valid_o), 64'd1);
        srst_i = 1'b1;
        drive(0, '0, 0, 0, '0, '0); step();
        check("midrst_valid", 64'(ex_valid_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        srst_i = 1'b0;
        drive(1, mk(FUNC_ADD, 5'd10, 5'd1, 5'd1, 6'd0), 1, 0, '0, '0); step();
        check("midrst_r1", 64'(rs1_data_o), 64'd0);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(11, 63)) : 6'($urandom_range(0, 10));
            srst_i = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0,
                  mk(f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 6'($urandom)),
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 4,
                  5'($urandom_range(0, 7)), $urandom);
            step();
        end
        srst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
